// File: rtl/pzcorebus_response_generator.sv
// ============================================================================
// Module   : pzcorebus_response_generator
// Brief    : Memory-profile pzcorebus target; absorbs write data and returns
//            address-pattern read data with correct beat/slast encoding.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pzcorebus_response_generator #(
    parameter int ID_WIDTH          = 8,
    parameter int ADDRESS_WIDTH     = 32,
    parameter int LENGTH_WIDTH      = 5,
    parameter int MAX_LENGTH        = 32,
    parameter int DATA_WIDTH        = 64,
    parameter int UNIT_DATA_WIDTH   = 32,
    parameter int MEMORY_H          = 0,
    parameter int RESPONSE_BOUNDARY = 64
) (
    input  logic                     clk,
    input  logic                     i_rst_n,
    input  logic                     i_mcmd_valid,
    output logic                     o_scmd_accept,
    input  logic [3:0]               i_mcmd,
    input  logic [ID_WIDTH-1:0]      i_mid,
    input  logic [ADDRESS_WIDTH-1:0] i_maddr,
    input  logic [LENGTH_WIDTH-1:0]  i_mlength,
    input  logic                     i_mdata_valid,
    output logic                     o_sdata_accept,
    input  logic [DATA_WIDTH-1:0]    i_mdata,
    input  logic                     i_mdata_last,
    output logic                     o_sresp_valid,
    input  logic                     i_mresp_accept,
    output logic                     o_sresp,
    output logic [ID_WIDTH-1:0]      o_sid,
    output logic                     o_serror,
    output logic [DATA_WIDTH-1:0]    o_sdata,
    output logic [1:0]               o_slast,
    output logic                     o_burst_error
);

    localparam int DATA_BYTE      = DATA_WIDTH / 8;
    localparam int UNIT_BYTE      = UNIT_DATA_WIDTH / 8;
    localparam int DATA_SIZE      = DATA_BYTE / UNIT_BYTE;
    localparam int ALIGN          = $clog2(DATA_BYTE);
    localparam int BOUNDARY_BEATS = (RESPONSE_BOUNDARY / DATA_BYTE) < 1 ? 1
                                  : (RESPONSE_BOUNDARY / DATA_BYTE);
    localparam int CW             = $clog2(MAX_LENGTH + DATA_SIZE) + 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_DATA = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    // Command encoding: bit3 = non-posted, bit2 = carries write data.
    localparam logic [3:0] c_CMD_READ      = 4'b1000;
    localparam logic [3:0] c_CMD_ATOMIC_NP = 4'b1110;

    logic [1:0]               r_state;
    logic [3:0]               r_cmd;
    logic [ID_WIDTH-1:0]      r_id;
    logic [ADDRESS_WIDTH-1:0] r_beat_addr;
    logic [CW-1:0]            r_beats;
    logic [CW-1:0]            r_count;
    logic                     r_error;
    logic                     r_burst_error;

    logic [CW-1:0]            w_len;
    logic [CW-1:0]            w_offset;
    logic [CW-1:0]            w_beats;
    logic [CW:0]              w_count_inc;
    logic                     w_mismatch;
    logic                     w_is_read;
    logic                     w_final;
    logic                     w_boundary;
    logic                     w_in_resp;
    logic [ADDRESS_WIDTH-1:0] w_next_word;
    logic [DATA_WIDTH-1:0]    w_addr_ext;
    logic                     w_unused;

    assign w_len      = (i_mlength == '0) ? CW'(MAX_LENGTH) : CW'(i_mlength);
    assign w_offset   = CW'((i_maddr % ADDRESS_WIDTH'(DATA_BYTE)) / ADDRESS_WIDTH'(UNIT_BYTE));
    assign w_beats    = (w_len + w_offset + CW'(DATA_SIZE - 1)) / CW'(DATA_SIZE);

    assign w_count_inc = {1'b0, r_count} + (CW+1)'(1);
    assign w_mismatch  = (w_count_inc != {1'b0, r_beats});
    assign w_is_read   = (r_cmd == c_CMD_READ);
    assign w_final     = w_is_read ? (w_count_inc == {1'b0, r_beats}) : 1'b1;
    assign w_in_resp   = (r_state == ST_RESP);

    // Boundary mark lands on the last beat before a RESPONSE_BOUNDARY crossing.
    assign w_next_word = (r_beat_addr >> ALIGN) + ADDRESS_WIDTH'(1);
    assign w_boundary  = ((w_next_word % ADDRESS_WIDTH'(BOUNDARY_BEATS)) == '0);

    generate
        if (DATA_WIDTH >= ADDRESS_WIDTH) begin : g_addr_zext
            assign w_addr_ext = DATA_WIDTH'(r_beat_addr);
        end else begin : g_addr_trunc
            assign w_addr_ext = r_beat_addr[DATA_WIDTH-1:0];
        end
    endgenerate

    assign w_unused = ^i_mdata;

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state       <= ST_IDLE;
            r_cmd         <= '0;
            r_id          <= '0;
            r_beat_addr   <= '0;
            r_beats       <= '0;
            r_count       <= '0;
            r_error       <= 1'b0;
            r_burst_error <= 1'b0;
        end else begin
            r_burst_error <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (i_mcmd_valid) begin
                        r_cmd       <= i_mcmd;
                        r_id        <= i_mid;
                        r_beat_addr <= i_maddr & ~ADDRESS_WIDTH'(DATA_BYTE - 1);
                        r_beats     <= w_beats;
                        r_count     <= '0;
                        r_error     <= 1'b0;
                        if (i_mcmd[2]) begin
                            r_state <= ST_DATA;
                        end else if (i_mcmd[3]) begin
                            r_state <= ST_RESP;
                        end
                    end
                end
                ST_DATA: begin
                    if (i_mdata_valid) begin
                        if (i_mdata_last) begin
                            r_error       <= r_error | w_mismatch;
                            r_burst_error <= w_mismatch;
                            r_count       <= '0;
                            r_state       <= r_cmd[3] ? ST_RESP : ST_IDLE;
                        end else if (r_count != '1) begin
                            // Saturate so overlong bursts still compare as a mismatch.
                            r_count <= r_count + CW'(1);
                        end
                    end
                end
                ST_RESP: begin
                    if (i_mresp_accept) begin
                        if (w_final) begin
                            r_state <= ST_IDLE;
                        end else begin
                            r_count     <= r_count + CW'(1);
                            r_beat_addr <= r_beat_addr + ADDRESS_WIDTH'(DATA_BYTE);
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign o_scmd_accept  = (r_state == ST_IDLE);
    assign o_sdata_accept = (r_state == ST_DATA);
    assign o_sresp_valid  = w_in_resp;
    assign o_sresp        = w_in_resp & (w_is_read | (r_cmd == c_CMD_ATOMIC_NP));
    assign o_sid          = r_id;
    assign o_serror       = w_in_resp & r_error;
    assign o_sdata        = (w_in_resp & w_is_read) ? w_addr_ext : '0;
    assign o_slast[0]     = w_in_resp & w_final;
    assign o_slast[1]     = w_in_resp & (MEMORY_H != 0) & (w_final | w_boundary);
    assign o_burst_error  = r_burst_error;

endmodule

`default_nettype wire
